sd_sector_client: RTL and testbench

SD_SECTOR_CLIENT -- requirements
Module: sd_sector_client

---
 rtl/sd_client_pkg.sv | 16 +
 rtl/sd_sector_ram.sv | 27 ++
 rtl/sd_sector_client.sv | 116 +++++++++++
 tb/tb_sd_sector_client.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_client_pkg.sv
// Shared types and sizes for the SD sector client and its sector buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sd_client_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int ADDR_W       = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sd_sector_ram.sv
// One-sector byte buffer, true dual port: port A for the host, port B for the SD side.
// Latency: one cycle on both read ports, read-before-write on address collisions.
// Backpressure: none; both ports accept an access every cycle.
module sd_sector_ram
    import sd_client_pkg::*;
(
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_we,
    input  logic [7:0]        a_din,
    output logic [7:0]        a_dout,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_we,
    input  logic [7:0]        b_din,
    output logic [7:0]        b_dout
);

    logic [7:0] mem [SECTOR_BYTES];

    always_ff @(posedge clk_i) begin
        if (a_we) mem[a_addr] <= a_din;
        if (b_we) mem[b_addr] <= b_din;
        a_dout <= mem[a_addr];
        b_dout <= mem[b_addr];
    end

endmodule

// File: rtl/sd_sector_client.sv
// Moves one 512-byte sector between a local buffer and an SD image responder.
// Latency: request issued the cycle after the command; done_o one cycle after ack falls or timeout.
// Backpressure: commands are ignored unless idle; host writes are ignored while busy_o is high.
module sd_sector_client
    import sd_client_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic              clk_i,
    input  logic              res_n_i,
    input  logic              cmd_rd_i,
    input  logic              cmd_wr_i,
    input  logic [31:0]       cmd_lba_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic              host_we_i,
    input  logic [7:0]        host_data_i,
    output logic [7:0]        host_data_o,
    output logic [31:0]       sd_lba_o,
    output logic              sd_rd_o,
    output logic              sd_wr_o,
    input  logic              sd_ack_i,
    input  logic [ADDR_W-1:0] sd_buff_addr_i,
    input  logic [7:0]        sd_buff_dout_i,
    input  logic              sd_buff_wr_i,
    output logic [7:0]        sd_buff_din_o
);

    localparam logic [19:0] TO_LAST = 20'(TIMEOUT - 1);
    localparam logic [9:0]  FULL    = 10'(SECTOR_BYTES);

    state_t      state;
    logic        is_rd;
    logic [19:0] to_cnt;
    logic [9:0]  strb_cnt;
    logic        xfer_strb;
    logic [9:0]  strb_next;

    assign xfer_strb = (state == ST_XFER) && sd_buff_wr_i;
    // Saturating so an over-long stream still reads as a complete sector.
    assign strb_next = (xfer_strb && strb_cnt != FULL) ? strb_cnt + 10'd1 : strb_cnt;

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            state    <= ST_IDLE;
            is_rd    <= 1'b0;
            to_cnt   <= '0;
            strb_cnt <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            sd_rd_o  <= 1'b0;
            sd_wr_o  <= 1'b0;
            sd_lba_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_rd_i || cmd_wr_i) begin
                        sd_lba_o <= cmd_lba_i;
                        busy_o   <= 1'b1;
                        is_rd    <= cmd_rd_i;
                        sd_rd_o  <= cmd_rd_i;
                        sd_wr_o  <= !cmd_rd_i;
                        to_cnt   <= '0;
                        strb_cnt <= '0;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sd_ack_i) begin
                        sd_rd_o <= 1'b0;
                        sd_wr_o <= 1'b0;
                        state   <= ST_XFER;
                    end else if (to_cnt == TO_LAST) begin
                        sd_rd_o <= 1'b0;
                        sd_wr_o <= 1'b0;
                        err_o   <= 1'b1;
                        done_o  <= 1'b1;
                        busy_o  <= 1'b0;
                        state   <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + 20'd1;
                    end
                end
                ST_XFER: begin
                    strb_cnt <= strb_next;
                    if (!sd_ack_i) begin
                        err_o  <= is_rd && (strb_next != FULL);
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    sd_sector_ram u_ram (
        .clk_i  (clk_i),
        .a_addr (host_addr_i),
        .a_we   (host_we_i && !busy_o),
        .a_din  (host_data_i),
        .a_dout (host_data_o),
        .b_addr (sd_buff_addr_i),
        .b_we   (xfer_strb && is_rd),
        .b_din  (sd_buff_dout_i),
        .b_dout (sd_buff_din_o)
    );

endmodule

// File: tb/tb_sd_sector_client.sv
// Randomized bench for sd_sector_client with a transaction-level reference model.
module tb_sd_sector_client;

    logic        clk_i = 1'b0;
    logic        res_n_i = 1'b0;
    logic        cmd_rd_i = 1'b0;
    logic        cmd_wr_i = 1'b0;
    logic [31:0] cmd_lba_i = '0;
    logic        busy_o, done_o, err_o;
    logic [8:0]  host_addr_i = '0;
    logic        host_we_i = 1'b0;
    logic [7:0]  host_data_i = '0;
    logic [7:0]  host_data_o;
    logic [31:0] sd_lba_o;
    logic        sd_rd_o, sd_wr_o;
    logic        sd_ack_i = 1'b0;
    logic [8:0]  sd_buff_addr_i = '0;
    logic [7:0]  sd_buff_dout_i = '0;
    logic        sd_buff_wr_i = 1'b0;
    logic [7:0]  sd_buff_din_o;

    sd_sector_client #(.TIMEOUT(16)) dut (
        .clk_i(clk_i), .res_n_i(res_n_i),
        .cmd_rd_i(cmd_rd_i), .cmd_wr_i(cmd_wr_i), .cmd_lba_i(cmd_lba_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .host_addr_i(host_addr_i), .host_we_i(host_we_i),
        .host_data_i(host_data_i), .host_data_o(host_data_o),
        .sd_lba_o(sd_lba_o), .sd_rd_o(sd_rd_o), .sd_wr_o(sd_wr_o),
        .sd_ack_i(sd_ack_i), .sd_buff_addr_i(sd_buff_addr_i),
        .sd_buff_dout_i(sd_buff_dout_i), .sd_buff_wr_i(sd_buff_wr_i),
        .sd_buff_din_o(sd_buff_din_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Reference model: buffer image plus expected control outputs for the current cycle.
    logic [7:0] mem [512];
    bit         known [512];
    logic       e_busy = 0, e_done = 0, e_err = 0, e_rd = 0, e_wr = 0;
    logic [31:0] e_lba = '0;
    logic [7:0] e_hd = '0, e_din = '0;
    bit         hd_ok = 0, din_ok = 0;
    bit         m_sd_we = 0;
    bit         chk_en = 0;
    bit         host_rnd = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk_i) begin
        cyc++;
        if (!res_n_i) begin
            hd_ok  = 0;
            din_ok = 0;
        end else begin
            hd_ok  = known[host_addr_i];
            e_hd   = mem[host_addr_i];
            din_ok = known[sd_buff_addr_i];
            e_din  = mem[sd_buff_addr_i];
            if (host_we_i && !e_busy) begin
                hd_ok = 0;
                if (host_addr_i == sd_buff_addr_i) din_ok = 0;
                mem[host_addr_i]   = host_data_i;
                known[host_addr_i] = 1;
            end
            if (sd_buff_wr_i && m_sd_we) begin
                din_ok = 0;
                if (host_addr_i == sd_buff_addr_i) hd_ok = 0;
                mem[sd_buff_addr_i]   = sd_buff_dout_i;
                known[sd_buff_addr_i] = 1;
            end
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("busy", 32'(busy_o), 32'(e_busy));
            check("done", 32'(done_o), 32'(e_done));
            check("err", 32'(err_o), 32'(e_err));
            check("sd_rd", 32'(sd_rd_o), 32'(e_rd));
            check("sd_wr", 32'(sd_wr_o), 32'(e_wr));
            if (e_busy || e_done) check("sd_lba", sd_lba_o, e_lba);
            if (hd_ok) check("host_data", 32'(host_data_o), 32'(e_hd));
            if (din_ok) check("sd_din", 32'(sd_buff_din_o), 32'(e_din));
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
        if (host_rnd) begin
            host_addr_i = 9'($urandom);
            host_we_i   = ($urandom_range(3) == 0);
            host_data_i = 8'($urandom);
        end
    endtask

    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] lba, input int dly,
                          input int nstrb, input bit patt, input bit noisy, input bit pin38,
                          output bit d_seen, output bit e_seen);
        bit is_rd = rd;
        int acc;
        cmd_rd_i = rd; cmd_wr_i = wr; cmd_lba_i = lba;
        step();
        cmd_rd_i = 0; cmd_wr_i = 0;
        e_busy = 1; e_rd = is_rd; e_wr = !is_rd; e_lba = lba;
        for (int i = 0; i < dly; i++) begin
            if (noisy) begin
                cmd_rd_i = 1'($urandom); cmd_wr_i = 1'($urandom); cmd_lba_i = $urandom;
                sd_buff_wr_i = 1'($urandom);
                sd_buff_addr_i = 9'($urandom); sd_buff_dout_i = 8'($urandom);
            end
            step();
        end
        cmd_rd_i = 0; cmd_wr_i = 0; sd_buff_wr_i = 0;
        sd_ack_i = 1;
        step();
        e_rd = 0; e_wr = 0; m_sd_we = is_rd;
        for (int i = 0; i < nstrb; i++) begin
            if (noisy && $urandom_range(3) == 0) begin
                sd_buff_wr_i = 0;
                step();
            end
            sd_buff_wr_i = 1;
            sd_buff_addr_i = 9'(i);
            sd_buff_dout_i = patt ? (8'(i) ^ 8'h5A) : 8'($urandom);
            step();
            if (pin38 && i == 'h3C) check("wr_din_3c", 32'(sd_buff_din_o), 32'h3C);
        end
        sd_buff_wr_i = 0; sd_ack_i = 0;
        step();
        acc = (nstrb > 512) ? 512 : nstrb;
        m_sd_we = 0; e_busy = 0; e_done = 1; e_err = is_rd && (acc != 512);
        d_seen = done_o; e_seen = err_o;
        if (noisy) begin
            cmd_rd_i = 1'($urandom); cmd_lba_i = $urandom;
        end
        step();
        cmd_rd_i = 0;
        e_done = 0;
    endtask

    initial begin
        bit d, e;
        bit r, w;
        int n;
        repeat (3) step();
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_sd_rd", 32'(sd_rd_o), 0);
        check("rst_sd_wr", 32'(sd_wr_o), 0);
        check("rst_lba", sd_lba_o, 0);
        res_n_i = 1; chk_en = 1;
        step();

        for (int i = 0; i < 512; i++) begin
            host_we_i = 1; host_addr_i = 9'(i); host_data_i = 8'(i);
            step();
        end
        host_we_i = 0;
        step();

        do_txn(0, 1, 32'd7, 3, 512, 0, 0, 1, d, e);
        check("wr_done", 32'(d), 1);
        check("wr_err", 32'(e), 0);

        do_txn(1, 0, 32'h10, 5, 512, 1, 0, 0, d, e);
        check("rd_done", 32'(d), 1);
        check("rd_err", 32'(e), 0);
        host_addr_i = 9'h1FF;
        step();
        check("host_1ff", 32'(host_data_o), 32'hA5);
        host_addr_i = 9'h000;
        step();
        check("host_000", 32'(host_data_o), 32'h5A);

        cmd_rd_i = 1; cmd_lba_i = 32'hDEAD_0001;
        step();
        cmd_rd_i = 0;
        e_busy = 1; e_rd = 1; e_lba = 32'hDEAD_0001;
        for (n = 2; n <= 17; n++) begin
            step();
            if (n == 16) check("to_not_yet", 32'(done_o), 0);
            if (n == 17) begin
                e_busy = 0; e_rd = 0; e_done = 1; e_err = 1;
            end
        end
        check("to_done", 32'(done_o), 1);
        check("to_err", 32'(err_o), 1);
        check("to_sd_rd", 32'(sd_rd_o), 0);
        step();
        e_done = 0;

        do_txn(1, 0, 32'h0000_0300, 4, 300, 0, 0, 0, d, e);
        check("short_done", 32'(d), 1);
        check("short_err", 32'(e), 1);

        do_txn(1, 0, 32'h0000_0515, 2, 515, 0, 0, 0, d, e);
        check("sat_err", 32'(e), 0);

        do_txn(1, 1, 32'h0000_0042, 6, 512, 0, 1, 0, d, e);
        check("both_done", 32'(d), 1);
        check("both_err", 32'(e), 0);

        cmd_rd_i = 1; cmd_lba_i = 32'h0BAD_F00D;
        step();
        cmd_rd_i = 0;
        e_busy = 1; e_rd = 1; e_lba = 32'h0BAD_F00D;
        step(); step();
        sd_ack_i = 1;
        step();
        e_rd = 0; m_sd_we = 1;
        for (int i = 0; i < 20; i++) begin
            sd_buff_wr_i = 1; sd_buff_addr_i = 9'(i); sd_buff_dout_i = 8'($urandom);
            step();
        end
        @(posedge clk_i);
        #3;
        res_n_i = 0; sd_ack_i = 0; sd_buff_wr_i = 0; m_sd_we = 0;
        e_busy = 0; e_done = 0; e_err = 0; e_rd = 0; e_wr = 0; e_lba = '0;
        for (int i = 0; i < 512; i++) known[i] = 0;
        #1;
        check("arst_busy", 32'(busy_o), 0);
        check("arst_done", 32'(done_o), 0);
        check("arst_err", 32'(err_o), 0);
        check("arst_sd_rd", 32'(sd_rd_o), 0);
        check("arst_sd_wr", 32'(sd_wr_o), 0);
        check("arst_lba", sd_lba_o, 0);
        step(); step();
        res_n_i = 1;
        step();
        do_txn(1, 0, 32'h0000_0099, 3, 512, 0, 0, 0, d, e);
        check("post_rst_done", 32'(d), 1);
        check("post_rst_err", 32'(e), 0);

        host_rnd = 1;
        for (int t = 0; t < 10; t++) begin
            r = 1'($urandom);
            w = r ? 1'($urandom) : 1'b1;
            case ($urandom_range(2))
                0: n = 512;
                1: n = $urandom_range(511, 1);
                default: n = $urandom_range(520, 513);
            endcase
            do_txn(r, w, $urandom, $urandom_range(10, 1), n, 0, 1, 0, d, e);
        end
        host_rnd = 0; host_we_i = 0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
